// File: rtl/adc_conv_scheduler.sv
// ADC conversion scheduler: brings up the ADC over a byte-wide SPI engine,
// then arbitrates requesters round-robin and runs one single-shot conversion
// per grant, returning the 24-bit result with a one-cycle ack.
module adc_conv_scheduler #(
    parameter int unsigned NREQ         = 4,
    parameter logic [23:0] CSR_WORD     = 24'h000000,
    parameter int unsigned DRDY_TIMEOUT = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic [23:0]     data,
    output logic            ready,
    output logic            err,
    output logic            spi_start,
    output logic [7:0]      spi_tx,
    input  logic            spi_done,
    input  logic [7:0]      spi_rx,
    input  logic            adc_sdo,
    output logic            adc_cs_n
);

    typedef enum logic [3:0] {
        StInit,
        StSetup,
        StCal,
        StCalWait,
        StIdle,
        StConv,
        StDrdyWait,
        StRead,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pending_q, pending_d;
    logic [31:0]     tmo_q, tmo_d;
    logic [2:0]      chan_q, chan_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [15:0]     shift_q, shift_d;
    logic [1:0]      sdo_sync_q;
    logic            sdo_s;

    logic            spi_start_q, spi_start_d;
    logic [7:0]      spi_tx_q, spi_tx_d;
    logic            cs_n_q, cs_n_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [23:0]     data_q, data_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    logic            send_en;
    logic [7:0]      tx_byte;
    logic            last_byte;
    logic            byte_done;

    logic [7:0]      req_ext;
    logic            gnt_found;
    logic [2:0]      gnt_idx;
    logic [2:0]      gnt_next;
    logic [3:0]      cand;

    assign sdo_s   = sdo_sync_q[1];
    assign req_ext = 8'(req);

    // Round-robin search starting at ptr_q, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand      = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            if (!gnt_found && req_ext[cand[2:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[2:0];
            end
        end
        gnt_next = (({1'b0, gnt_idx} + 4'd1) == 4'(NREQ)) ? 3'd0 : gnt_idx + 3'd1;
    end

    // Byte to send in the current state, whether sending is allowed, and
    // whether the current byte is the last one of the state.
    always_comb begin
        send_en   = 1'b0;
        tx_byte   = 8'h00;
        last_byte = 1'b0;
        case (state_q)
            StInit: begin
                send_en   = 1'b1;
                tx_byte   = (cnt_q == 4'd15) ? 8'hFE : 8'hFF;
                last_byte = (cnt_q == 4'd15);
            end
            StSetup: begin
                send_en   = 1'b1;
                last_byte = (cnt_q == 4'd3);
                case (cnt_q)
                    4'd0:    tx_byte = 8'h05;
                    4'd1:    tx_byte = CSR_WORD[23:16];
                    4'd2:    tx_byte = CSR_WORD[15:8];
                    default: tx_byte = CSR_WORD[7:0];
                endcase
            end
            StCal: begin
                send_en   = 1'b1;
                tx_byte   = 8'h81;
                last_byte = 1'b1;
            end
            StCalWait: begin
                // Flag-clearing read only once calibration reports done.
                send_en   = ~sdo_s;
                tx_byte   = 8'h00;
                last_byte = 1'b1;
            end
            StConv: begin
                send_en   = 1'b1;
                tx_byte   = 8'h80 | {2'b00, chan_q, 3'b000};
                last_byte = 1'b1;
            end
            StRead: begin
                send_en   = 1'b1;
                tx_byte   = 8'h00;
                last_byte = (cnt_q == 4'd3);
            end
            default: begin
                send_en = 1'b0;
            end
        endcase
    end

    // Next-state, SPI handshake and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        tmo_d       = tmo_q;
        chan_d      = chan_q;
        ptr_d       = ptr_q;
        shift_d     = shift_q;
        spi_start_d = 1'b0;
        spi_tx_d    = spi_tx_q;
        cs_n_d      = cs_n_q;
        ack_d       = '0;
        data_d      = data_q;
        ready_d     = ready_q;
        err_d       = 1'b0;
        byte_done   = 1'b0;

        // One transfer in flight at a time; a done with nothing pending is ignored.
        if (send_en && !pending_q) begin
            spi_start_d = 1'b1;
            spi_tx_d    = tx_byte;
            pending_d   = 1'b1;
            cs_n_d      = 1'b0;
        end
        if (pending_q && spi_done) begin
            pending_d = 1'b0;
            byte_done = 1'b1;
        end

        case (state_q)
            StInit: begin
                if (byte_done) begin
                    cnt_d = cnt_q + 4'd1;
                    if (last_byte) begin
                        state_d = StSetup;
                        cnt_d   = 4'd0;
                        cs_n_d  = 1'b1;
                    end
                end
            end
            StSetup: begin
                if (byte_done) begin
                    cnt_d = cnt_q + 4'd1;
                    if (last_byte) begin
                        state_d = StCal;
                        cnt_d   = 4'd0;
                        cs_n_d  = 1'b1;
                    end
                end
            end
            StCal: begin
                // Chip select stays low so the ADC can report ready on sdo.
                if (byte_done) begin
                    state_d = StCalWait;
                end
            end
            StCalWait: begin
                if (byte_done) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                    cs_n_d  = 1'b1;
                end
            end
            StIdle: begin
                if (gnt_found) begin
                    chan_d  = gnt_idx;
                    ptr_d   = gnt_next;
                    cnt_d   = 4'd0;
                    state_d = StConv;
                end
            end
            StConv: begin
                if (byte_done) begin
                    tmo_d   = 32'd0;
                    state_d = StDrdyWait;
                end
            end
            StDrdyWait: begin
                if (!sdo_s) begin
                    cnt_d   = 4'd0;
                    state_d = StRead;
                end else if (tmo_q == 32'(DRDY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    ready_d = 1'b0;
                    cs_n_d  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = StInit;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StRead: begin
                if (byte_done) begin
                    cnt_d = cnt_q + 4'd1;
                    // First received byte only clears the ready flag.
                    if (cnt_q != 4'd0) begin
                        shift_d = {shift_q[7:0], spi_rx};
                    end
                    if (last_byte) begin
                        data_d = {shift_q, spi_rx};
                        for (int k = 0; k < NREQ; k++) begin
                            ack_d[k] = (chan_q == 3'(k));
                        end
                        cs_n_d  = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInit;
            cnt_q       <= 4'd0;
            pending_q   <= 1'b0;
            tmo_q       <= 32'd0;
            chan_q      <= 3'd0;
            ptr_q       <= 3'd0;
            shift_q     <= 16'd0;
            spi_start_q <= 1'b0;
            spi_tx_q    <= 8'h00;
            cs_n_q      <= 1'b1;
            ack_q       <= '0;
            data_q      <= 24'd0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            tmo_q       <= tmo_d;
            chan_q      <= chan_d;
            ptr_q       <= ptr_d;
            shift_q     <= shift_d;
            spi_start_q <= spi_start_d;
            spi_tx_q    <= spi_tx_d;
            cs_n_q      <= cs_n_d;
            ack_q       <= ack_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    // Two-flop synchronizer for the asynchronous ADC ready line (idle high).
    always_ff @(posedge clk) begin
        if (rst) begin
            sdo_sync_q <= 2'b11;
        end else begin
            sdo_sync_q <= {sdo_sync_q[0], adc_sdo};
        end
    end

    assign spi_start = spi_start_q;
    assign spi_tx    = spi_tx_q;
    assign adc_cs_n  = cs_n_q;
    assign ack       = ack_q;
    assign data      = data_q;
    assign ready     = ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Scoreboard bench for adc_conv_scheduler: stimulus pushes expected SPI bytes,
// acks and errors; a monitor pops and compares as the DUT produces them.
module tb_adc_conv_scheduler;

    localparam int          NREQ = 4;
    localparam logic [23:0] CSR  = 24'hA1B2C3;
    localparam int          TMO  = 100;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [23:0]     data;
    logic            ready;
    logic            err;
    logic            spi_start;
    logic [7:0]      spi_tx;
    logic            spi_done;
    logic [7:0]      spi_rx;
    logic            adc_sdo;
    logic            adc_cs_n;

    adc_conv_scheduler #(
        .NREQ(NREQ),
        .CSR_WORD(CSR),
        .DRDY_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .ack(ack),
        .data(data),
        .ready(ready),
        .err(err),
        .spi_start(spi_start),
        .spi_tx(spi_tx),
        .spi_done(spi_done),
        .spi_rx(spi_rx),
        .adc_sdo(adc_sdo),
        .adc_cs_n(adc_cs_n)
    );

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          last_done_cyc = 0;
    int          start_cnt = 0;
    int          overlap_cnt = 0;
    int          plan_idx = 0;
    logic [7:0]  rx_mem [0:255];
    logic [7:0]  exp_tx_q [$];
    logic [3:0]  exp_ack_q [$];
    logic [23:0] exp_data_q [$];
    bit          exp_err_q [$];

    task automatic check(input bit ok, input string name, input logic [31:0] got,
                         input logic [31:0] want);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic push_tx(input logic [7:0] t, input logic [7:0] r);
        exp_tx_q.push_back(t);
        if (plan_idx < 256) rx_mem[plan_idx] = r;
        plan_idx++;
    endtask

    task automatic push_init();
        for (int i = 0; i < 15; i++) push_tx(8'hFF, 8'h00);
        push_tx(8'hFE, 8'h00);
        push_tx(8'h05, 8'h00);
        push_tx(8'hA1, 8'h00);
        push_tx(8'hB2, 8'h00);
        push_tx(8'hC3, 8'h00);
        push_tx(8'h81, 8'h00);
        push_tx(8'h00, 8'h00);
    endtask

    // Conversion on channel c whose result is {5A, n, C0|c}.
    task automatic push_conv(input logic [2:0] c, input logic [7:0] n);
        logic [7:0] lo;
        logic [3:0] a;
        lo = 8'hC0 | {5'b00000, c};
        a  = 4'b0001 << c;
        push_tx(8'h80 | {2'b00, c, 3'b000}, 8'h00);
        push_tx(8'h00, 8'h00);
        push_tx(8'h00, 8'h5A);
        push_tx(8'h00, n);
        push_tx(8'h00, lo);
        exp_ack_q.push_back(a);
        exp_data_q.push_back({8'h5A, n, lo});
    endtask

    task automatic wait_ready(input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        check(seen, "ready_timeout", 32'(ready), 32'd1);
        if (seen) begin
            check(exp_tx_q.size() == 0, "ready_after_all_bytes", 32'(exp_tx_q.size()), 32'd0);
            check((cyc - last_done_cyc) == 1, "ready_one_after_done",
                  32'(cyc - last_done_cyc), 32'd1);
        end
    endtask

    task automatic wait_ack(input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check(1'b0, "ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // SPI byte engine: done pulse 8 cycles after each start.
    initial begin
        int remain;
        int cur;
        bit busy;
        busy     = 1'b0;
        remain   = 0;
        cur      = 0;
        spi_done = 1'b0;
        spi_rx   = 8'h00;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (spi_start) begin
                if (busy) begin
                    overlap_cnt++;
                end else begin
                    busy   = 1'b1;
                    remain = 8;
                    cur    = start_cnt;
                    start_cnt++;
                end
            end else if (busy) begin
                remain--;
                if (remain == 0) begin
                    spi_done      = 1'b1;
                    spi_rx        = (cur < 256) ? rx_mem[cur] : 8'h00;
                    last_done_cyc = cyc;
                    busy          = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every DUT event against the scoreboard queues.
    initial begin
        logic [7:0]  wt;
        logic [3:0]  wa;
        logic [23:0] wd;
        bit          we;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                if (exp_tx_q.size() == 0) begin
                    check(1'b0, "tx_unexpected", 32'(spi_tx), 32'd0);
                end else begin
                    wt = exp_tx_q.pop_front();
                    check(spi_tx == wt, "tx_byte", 32'(spi_tx), 32'(wt));
                    check(adc_cs_n == 1'b0, "tx_cs_low", 32'(adc_cs_n), 32'd0);
                end
            end
            if (ack != '0) begin
                if (exp_ack_q.size() == 0) begin
                    check(1'b0, "ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    wa = exp_ack_q.pop_front();
                    wd = exp_data_q.pop_front();
                    check(ack == wa, "ack_onehot", 32'(ack), 32'(wa));
                    check(data == wd, "ack_data", 32'(data), 32'(wd));
                    check(adc_cs_n && ready, "ack_cs_ready", 32'({adc_cs_n, ready}), 32'd3);
                end
            end
            if (err) begin
                if (exp_err_q.size() == 0) begin
                    check(1'b0, "err_unexpected", 32'(err), 32'd0);
                end else begin
                    we = exp_err_q.pop_front();
                    // Cycles spent waiting after the conversion command finished.
                    check((cyc - last_done_cyc - 1) == TMO, "err_delay",
                          32'(cyc - last_done_cyc - 1), 32'(TMO));
                    check(ready == 1'b0, "err_ready_low", 32'(ready), 32'd0);
                    check(we && adc_cs_n, "err_cs_high", 32'(adc_cs_n), 32'd1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    // Stimulus.
    initial begin
        int order [8];
        int base;
        bit seen;
        order = '{0, 1, 2, 3, 0, 2, 3, 0};
        for (int i = 0; i < 256; i++) rx_mem[i] = 8'h00;
        rst     = 1'b1;
        req     = '0;
        adc_sdo = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        check(ack == '0, "rst_ack", 32'(ack), 32'd0);
        check(data == 24'd0, "rst_data", 32'(data), 32'd0);
        check(ready == 1'b0, "rst_ready", 32'(ready), 32'd0);
        check(err == 1'b0, "rst_err", 32'(err), 32'd0);
        check(spi_start == 1'b0, "rst_spi_start", 32'(spi_start), 32'd0);
        check(spi_tx == 8'h00, "rst_spi_tx", 32'(spi_tx), 32'd0);
        check(adc_cs_n == 1'b1, "rst_cs_n", 32'(adc_cs_n), 32'd1);

        // Power-up: resync, setup, calibration.
        push_init();
        rst = 1'b0;
        wait_ready(1000);

        // All requesters held, then requester 1 drops out.
        for (int i = 0; i < 8; i++) push_conv(3'(order[i]), 8'(i));
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_ack(300);
        req = 4'b1101;
        for (int i = 0; i < 3; i++) wait_ack(300);
        req = '0;
        repeat (3) @(negedge clk);
        check(data == 24'h5A07C0, "data_holds", 32'(data), 32'h5A07C0);

        // Channel 2 conversion with data-ready after 50 cycles; req dropped mid-way.
        adc_sdo = 1'b1;
        repeat (4) @(negedge clk);
        push_tx(8'h90, 8'h00);
        push_tx(8'h00, 8'h00);
        push_tx(8'h00, 8'h12);
        push_tx(8'h00, 8'h34);
        push_tx(8'h00, 8'h56);
        exp_ack_q.push_back(4'b0100);
        exp_data_q.push_back(24'h123456);
        req = 4'b0100;
        repeat (50) @(negedge clk);
        adc_sdo = 1'b0;
        req     = '0;
        wait_ack(300);

        // Data-ready timeout: err, no ack, full re-initialisation.
        adc_sdo = 1'b1;
        repeat (4) @(negedge clk);
        push_tx(8'h80, 8'h00);
        exp_err_q.push_back(1'b1);
        push_init();
        req  = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        check(seen, "err_timeout", 32'(err), 32'd1);
        req     = '0;
        adc_sdo = 1'b0;
        @(negedge clk);
        check(err == 1'b0, "err_one_cycle", 32'(err), 32'd0);
        check(ready == 1'b0, "ready_low_reinit", 32'(ready), 32'd0);
        wait_ready(1000);

        // Reset during the second read byte of a channel 1 conversion.
        push_tx(8'h88, 8'h00);
        push_tx(8'h00, 8'h00);
        push_tx(8'h00, 8'h00);
        base = start_cnt;
        req  = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start_cnt >= base + 3) begin
                seen = 1'b1;
                break;
            end
        end
        check(seen, "read_byte2_reached", 32'(start_cnt - base), 32'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        push_init();
        @(negedge clk);
        check(adc_cs_n == 1'b1, "abort_cs_n", 32'(adc_cs_n), 32'd1);
        check(ack == '0, "abort_ack", 32'(ack), 32'd0);
        check(ready == 1'b0, "abort_ready", 32'(ready), 32'd0);
        check(spi_start == 1'b0, "abort_spi_start", 32'(spi_start), 32'd0);
        check(data == 24'd0, "abort_data", 32'(data), 32'd0);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ready(1000);

        repeat (20) @(negedge clk);
        check(exp_tx_q.size() == 0, "tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
        check(exp_ack_q.size() == 0, "ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);
        check(exp_err_q.size() == 0, "err_queue_drained", 32'(exp_err_q.size()), 32'd0);
        check(overlap_cnt == 0, "spi_single_outstanding", 32'(overlap_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/adc_conv_scheduler.md
ADC_CONV_SCHEDULER -- requirements
Module: adc_conv_scheduler

Interface
REQ-001 Parameter NREQ, 4, number of requesters; requester i converts ADC channel i (0..NREQ-1, max 8).
REQ-002 Parameter CSR_WORD, 24'h000000, channel-setup register value written during setup.
REQ-003 Parameter DRDY_TIMEOUT, 1000000, clk cycles allowed for the ADC data-ready indication before timeout.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester conversion request level; held until matching ack.
REQ-007 ack  out  NREQ  one-hot, 1-cycle pulse; conversion result for that requester is on data.
REQ-008 data  out  24  conversion result; valid only in the ack cycle, holds its value otherwise.
REQ-009 ready  out  1  high once init/setup/calibration completes; low otherwise.
REQ-010 err  out  1  1-cycle pulse on data-ready timeout.
REQ-011 spi_start  out  1  1-cycle pulse launching one byte transfer to the SPI byte engine.
REQ-012 spi_tx  out  8  byte to shift out; stable from spi_start until spi_done.
REQ-013 spi_done  in  1  1-cycle pulse: transfer finished, spi_rx valid.
REQ-014 spi_rx  in  8  byte shifted in by the last transfer.
REQ-015 adc_sdo  in  1  ADC serial data line sampled as data-ready; low = conversion complete.
REQ-016 adc_cs_n  out  1  ADC chip select; low from first spi_start of a sequence until spi_done of its last byte.

Function
REQ-017 Exactly one SPI transfer outstanding: spi_start issued only when no transfer is pending; next spi_start no earlier than the cycle after spi_done.
REQ-018 States: INIT, SETUP, CAL, CAL_WAIT, IDLE, CONV, DRDY_WAIT, READ, DONE.
REQ-019 INIT: send 15 bytes 0xFF then one byte 0xFE (serial port resync); then SETUP.
REQ-020 SETUP: send 0x05 then CSR_WORD MSB-first (3 bytes); then CAL.
REQ-021 CAL: send 0x81 (self-offset calibration); CAL_WAIT waits adc_sdo low (2-flop synchronized), then sends one 0x00 byte to clear the flag; then IDLE with ready=1.
REQ-022 IDLE: round-robin arbiter; search starts at pointer p (reset 0); first i with req[i]=1 in order p, p+1 .. wrap mod NREQ is granted; p <= i+1 mod NREQ on grant.
REQ-023 Arbitration decision takes 1 cycle; req changes during CONV..DONE ignored until return to IDLE.
REQ-024 CONV: send 0x80 | (i<<3) (single conversion, channel i); then DRDY_WAIT.
REQ-025 DRDY_WAIT: counter from 0; synchronized adc_sdo low -> READ; counter reaching DRDY_TIMEOUT-1 -> err pulse, ack not asserted, return to INIT with ready=0.
REQ-026 READ: send 4 bytes 0x00; first rx byte discarded (flag clear), next three assembled MSB-first into 24-bit result.
REQ-027 DONE: data <= result, ack[i] pulses 1 cycle, adc_cs_n high, return to IDLE; next grant no earlier than following cycle.
REQ-028 Requester deasserting req mid-conversion: conversion completes and ack still pulses.
REQ-029 spi_done while no transfer pending: ignored.
REQ-030 Between sequences adc_cs_n high for at least 1 cycle.

Reset
REQ-031 rst dominates all inputs; mid-sequence reset aborts immediately, no ack, no err.
REQ-032 Reset values: ack=0, data=0, ready=0, err=0, spi_start=0, spi_tx=0x00, adc_cs_n=1, p=0, state=INIT.
REQ-033 First spi_start no earlier than the 2nd cycle after rst deasserts.

Verification
REQ-034 Release reset, SPI model acks each byte after 8 cycles -> tx bytes 15x0xFF, 0xFE, 0x05, CSR_WORD bytes, 0x81, 0x00; ready rises after last spi_done.
REQ-035 req=4'b0100, adc_sdo low after 50 cycles, rx 0x00,0x12,0x34,0x56 -> tx 0x90, four 0x00; ack=4'b0100 with data=24'h123456.
REQ-036 req=4'b1111 held -> acks in order 0,1,2,3,0; drop req[1] after its grant -> order 0,2,3,0.
REQ-037 req=4'b0001, adc_sdo held high -> err pulse at DRDY_TIMEOUT cycles, no ack, ready=0, INIT bytes resent.
REQ-038 rst asserted during READ byte 2 -> next cycle adc_cs_n=1, ack=0, state INIT; full init sequence repeats.
